// File: rtl/hack_spi_pkg.sv
// Shared constants for the Hack SPI responder: status word bit positions,
// the ACK command bit and the default byte sent when nothing is queued.
package hack_spi_pkg;

   localparam int ST_RX_READY  = 15;
   localparam int ST_TX_EMPTY  = 14;
   localparam int ST_OVERRUN   = 13;
   localparam int ST_CS_ACTIVE = 12;
   localparam int CMD_ACK      = 8;

   localparam logic [7:0] IDLE_FILL_DEFAULT = 8'hFF;

endpackage

// File: rtl/spi_sync.sv
// One asynchronous-input synchronizer chain followed by a rise/fall edge
// detector; the chain and the edge history both preset to RESET_VAL.
module spi_sync #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RESET_VAL   = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= {SYNC_STAGES{RESET_VAL}};
         prev_q <= RESET_VAL;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign q_o    = sync_q[SYNC_STAGES-1];
   assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
   assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder (MSB first, 8-bit frames) with a Hack CPU register port.
// Define SPI_SLAVE_IRQ_EN to add an irq pulse output on rx_ready/overrun rising.
module spi_slave
   import hack_spi_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] IDLE_FILL   = IDLE_FILL_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] in,
   input  logic        load,
   output logic [15:0] out,
   input  logic        spi_sck,
   input  logic        spi_mosi,
   input  logic        spi_csn,
   output logic        spi_miso
`ifdef SPI_SLAVE_IRQ_EN
   ,
   output logic        irq
`endif
);

   logic sck_rise, sck_fall, csn_s, csn_rise, csn_fall, mosi_s;
   logic unused_sck_s, unused_mosi_rise, unused_mosi_fall, unused_in_hi;

   spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
      .clk(clk), .reset(reset), .d_i(spi_sck),
      .q_o(unused_sck_s), .rise_o(sck_rise), .fall_o(sck_fall)
   );

   spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_csn (
      .clk(clk), .reset(reset), .d_i(spi_csn),
      .q_o(csn_s), .rise_o(csn_rise), .fall_o(csn_fall)
   );

   spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_mosi (
      .clk(clk), .reset(reset), .d_i(spi_mosi),
      .q_o(mosi_s), .rise_o(unused_mosi_rise), .fall_o(unused_mosi_fall)
   );

   assign unused_in_hi = ^in[15:9];

   logic [7:0] rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
   logic [7:0] hold_q, hold_d, rx_byte_q, rx_byte_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       rx_ready_q, rx_ready_d, tx_empty_q, tx_empty_d;
   logic       overrun_q, overrun_d, miso_q, miso_d;

   logic       cs_active, wr, ack, reload, byte_done;
   logic [7:0] rx_word;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_shift_q <= 8'hFF;
         tx_shift_q <= 8'hFF;
         hold_q     <= IDLE_FILL;
         rx_byte_q  <= 8'h00;
         bit_cnt_q  <= 3'd0;
         rx_ready_q <= 1'b0;
         tx_empty_q <= 1'b1;
         overrun_q  <= 1'b0;
         miso_q     <= 1'b1;
      end else begin
         rx_shift_q <= rx_shift_d;
         tx_shift_q <= tx_shift_d;
         hold_q     <= hold_d;
         rx_byte_q  <= rx_byte_d;
         bit_cnt_q  <= bit_cnt_d;
         rx_ready_q <= rx_ready_d;
         tx_empty_q <= tx_empty_d;
         overrun_q  <= overrun_d;
         miso_q     <= miso_d;
      end
   end

   always_comb begin
      rx_shift_d = rx_shift_q;
      tx_shift_d = tx_shift_q;
      hold_d     = hold_q;
      rx_byte_d  = rx_byte_q;
      bit_cnt_d  = bit_cnt_q;
      rx_ready_d = rx_ready_q;
      tx_empty_d = tx_empty_q;
      overrun_d  = overrun_q;

      cs_active = ~csn_s;
      wr        = load & ~in[CMD_ACK];
      ack       = load & in[CMD_ACK];
      rx_word   = {rx_shift_q[6:0], mosi_s};
      reload    = csn_fall | (sck_fall & cs_active & (bit_cnt_q == 3'd0));
      byte_done = sck_rise & cs_active & ~csn_fall & (bit_cnt_q == 3'd7);

      // Frame start or abort: restart the bit count and drop any partial byte.
      if (csn_fall || csn_rise) begin
         bit_cnt_d  = 3'd0;
         rx_shift_d = 8'hFF;
      end else if (sck_rise && cs_active) begin
         rx_shift_d = rx_word;
         bit_cnt_d  = bit_cnt_q + 3'd1;
      end

      if (reload) begin
         tx_shift_d = tx_empty_q ? IDLE_FILL : hold_q;
         tx_empty_d = 1'b1;
      end else if (sck_fall && cs_active) begin
         tx_shift_d = {tx_shift_q[6:0], 1'b0};
      end

      // A write in the reload cycle refills hold after the old byte was taken.
      if (wr) begin
         hold_d     = in[7:0];
         tx_empty_d = 1'b0;
      end

      if (ack) begin
         rx_ready_d = 1'b0;
         overrun_d  = 1'b0;
      end

      if (byte_done) begin
         rx_byte_d  = rx_word;
         rx_ready_d = 1'b1;
         if (rx_ready_q && !ack) overrun_d = 1'b1;
      end

      miso_d = cs_active ? tx_shift_q[7] : 1'b1;
   end

   always_comb begin
      out               = 16'h0000;
      out[ST_RX_READY]  = rx_ready_q;
      out[ST_TX_EMPTY]  = tx_empty_q;
      out[ST_OVERRUN]   = overrun_q;
      out[ST_CS_ACTIVE] = ~csn_s;
      out[7:0]          = rx_byte_q;
   end

   assign spi_miso = miso_q;

`ifdef SPI_SLAVE_IRQ_EN
   logic irq_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) irq_q <= 1'b0;
      else       irq_q <= (rx_ready_d & ~rx_ready_q) | (overrun_d & ~overrun_q);
   end

   assign irq = irq_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: drives SPI frames as a mode-0 master and
// CPU writes/ACKs, checking against a transaction-level model of the register.
module tb_spi_slave;

   localparam int HALF = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] din = 16'h0000;
   logic        load = 1'b0;
   logic [15:0] dout;
   logic        spi_sck = 1'b0;
   logic        spi_mosi = 1'b1;
   logic        spi_csn = 1'b1;
   logic        spi_miso;
`ifdef SPI_SLAVE_IRQ_EN
   logic        irq;
`endif

   spi_slave #(.SYNC_STAGES(2), .IDLE_FILL(8'hFF)) dut (
      .clk(clk), .reset(reset), .in(din), .load(load), .out(dout),
      .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_csn(spi_csn),
      .spi_miso(spi_miso)
`ifdef SPI_SLAVE_IRQ_EN
      , .irq(irq)
`endif
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_err    = 0;
   logic check_en = 1'b0;

   // Register model: what the CPU should see once the interface is idle.
   logic [7:0] m_hold, m_rx_byte;
   logic       m_tx_empty, m_rx_ready, m_overrun;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] exp_out();
      return {m_rx_ready, m_tx_empty, m_overrun, 1'b0, 4'b0000, m_rx_byte};
   endfunction

   task automatic model_reset();
      m_hold     = 8'hFF;
      m_rx_byte  = 8'h00;
      m_tx_empty = 1'b1;
      m_rx_ready = 1'b0;
      m_overrun  = 1'b0;
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         check("idle_out", dout, exp_out());
         check("idle_miso", {15'b0, spi_miso}, 16'h0001);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic settle();
      tick(5);
      check_en = 1'b1;
      tick(3 + int'($urandom_range(0, 3)));
      check_en = 1'b0;
   endtask

   task automatic cpu_write(input logic [7:0] b);
      din  = {8'h00, b};
      load = 1'b1;
      tick(1);
      load = 1'b0;
      din  = 16'h0000;
      m_hold     = b;
      m_tx_empty = 1'b0;
      settle();
   endtask

   task automatic cpu_ack();
      din  = 16'h0100;
      load = 1'b1;
      tick(1);
      load = 1'b0;
      din  = 16'h0000;
      m_rx_ready = 1'b0;
      m_overrun  = 1'b0;
      settle();
   endtask

   // Mode-0 master: nbits bits of m; ack_last fires an ACK on the clk the 8th bit lands.
   task automatic frame(input logic [7:0] m, input int nbits, input bit ack_last,
                        output logic [7:0] got);
      logic [7:0] exp_tx, sh;
      exp_tx     = m_tx_empty ? 8'hFF : m_hold;
      m_tx_empty = 1'b1;
      got        = 8'h00;
      sh         = m;
      spi_mosi   = sh[7];
      spi_csn    = 1'b0;
      tick(HALF);
      check("csn_fall_status", {14'b0, dout[14], dout[12]}, {14'b0, m_tx_empty, 1'b1});
      for (int i = 0; i < nbits; i++) begin
         got     = {got[6:0], spi_miso};
         spi_sck = 1'b1;
         if (ack_last && i == 7) begin
            tick(2);
            din  = 16'h0100;
            load = 1'b1;
            tick(1);
            load = 1'b0;
            din  = 16'h0000;
            tick(HALF - 3);
         end else begin
            tick(HALF);
         end
         spi_sck  = 1'b0;
         sh       = {sh[6:0], 1'b1};
         spi_mosi = sh[7];
         tick(HALF);
      end
      spi_csn  = 1'b1;
      spi_mosi = 1'b1;
      tick(HALF);
      check("miso_bits", {8'h00, got}, {8'h00, exp_tx >> (8 - nbits)});
      if (nbits == 8) begin
         if (ack_last) m_overrun = 1'b0;
         else          m_overrun = m_overrun | m_rx_ready;
         m_rx_ready = 1'b1;
         m_rx_byte  = m;
      end
      settle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [7:0] got;
      model_reset();
      tick(3);
      check("reset_out", dout, 16'h4000);
      check("reset_miso", {15'b0, spi_miso}, 16'h0001);
      reset = 1'b0;
      settle();

      frame(8'hA5, 8, 1'b0, got);
      check("a5_rx", dout, 16'hC0A5);
      check("a5_miso", {8'h00, got}, 16'h00FF);

      cpu_ack();
      cpu_write(8'h3C);
      check("write_3c", dout, 16'h00A5);
      frame(8'h00, 8, 1'b0, got);
      check("tx_3c", {8'h00, got}, 16'h003C);
      check("after_3c", dout, 16'hC000);

      cpu_ack();
      frame(8'h11, 8, 1'b0, got);
      frame(8'h22, 8, 1'b0, got);
      check("overrun", dout, 16'hE022);
      cpu_ack();
      check("ack_clear", dout, 16'h4022);

      frame(8'hF0, 5, 1'b0, got);
      check("abort_nochange", dout, 16'h4022);
      frame(8'h81, 8, 1'b0, got);
      check("after_abort", dout, 16'hC081);

      frame(8'h7E, 8, 1'b1, got);
      check("ack_at_done", dout, 16'hC07E);

      // Reset arriving in the middle of a byte.
      spi_csn  = 1'b0;
      spi_mosi = 1'b0;
      tick(HALF);
      repeat (3) begin
         spi_sck = 1'b1;
         tick(HALF);
         spi_sck = 1'b0;
         tick(HALF);
      end
      spi_sck = 1'b1;
      tick(2);
      #2 reset = 1'b1;
      #1;
      check("midbyte_reset_out", dout, 16'h4000);
      check("midbyte_reset_miso", {15'b0, spi_miso}, 16'h0001);
      spi_csn  = 1'b1;
      spi_sck  = 1'b0;
      spi_mosi = 1'b1;
      tick(3);
      reset = 1'b0;
      model_reset();
      settle();
      frame(8'h5A, 8, 1'b0, got);
      check("post_reset_rx", dout, 16'hC05A);
      check("post_reset_miso", {8'h00, got}, 16'h00FF);

      for (int op = 0; op < 150; op++) begin
         int r;
         r = int'($urandom_range(0, 9));
         if (r <= 2)      cpu_write(8'($urandom));
         else if (r <= 4) cpu_ack();
         else if (r <= 7) frame(8'($urandom), 8, 1'b0, got);
         else if (r == 8) frame(8'($urandom), int'($urandom_range(1, 7)), 1'b0, got);
         else             frame(8'($urandom), 8, 1'b1, got);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
